poly_mem_reader: RTL and testbench

Sequential read-out engine for the polynomial coefficient memories of the SNTRUP757 datapath. On a start pulse it walks the memory read address from 0 up to a latched polynomial degree, samples the memory's asynchronous read data, and presents each coefficient on a valid/ready stream with index and last flags. It is the read-side counterpart to the coefficient memories: it drives their read address port and feeds coefficients onward to the arithmetic units.

---
 rtl/poly_mem_reader.sv | 141 ++++++++++++++
 tb/tb_poly_mem_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_mem_reader.sv
// poly_mem_reader
// Walks a coefficient memory's read address from 0 up to a latched degree.
// Each asynchronously read coefficient goes out on a valid/ready stream
// together with its index and a last flag. The read address is registered,
// so the only combinational use of m_ready is the internal load decision.

module poly_mem_reader #(
    parameter int RAM_WIDTH     = 26,
    parameter int RAM_ADDR_BITS = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [RAM_ADDR_BITS-1:0] deg,
    output logic [RAM_ADDR_BITS-1:0] read_address,
    input  logic [RAM_WIDTH-1:0]     output_data,
    output logic [RAM_WIDTH-1:0]     m_data,
    output logic [RAM_ADDR_BITS-1:0] m_index,
    output logic                     m_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                   state_r;
    logic [RAM_ADDR_BITS-1:0] deg_q_r;
    logic [RAM_ADDR_BITS-1:0] addr_r;
    logic                     issued_all_r;
    logic [RAM_WIDTH-1:0]     m_data_r;
    logic [RAM_ADDR_BITS-1:0] m_index_r;
    logic                     m_last_r;
    logic                     m_valid_r;
    logic                     busy_r;
    logic                     done_r;

    logic                     load_s;
    logic                     accept_s;
    logic                     at_deg_s;

    // Decide whether the output slot takes a new coefficient this cycle
    always_comb begin
        load_s   = 1'b0;
        accept_s = m_valid_r & m_ready;
        at_deg_s = (addr_r == deg_q_r);
        if ((state_r == ST_STREAM) && !issued_all_r && (!m_valid_r || m_ready)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Pass sequencing, address walk and output beat registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            deg_q_r      <= {RAM_ADDR_BITS{1'b0}};
            addr_r       <= {RAM_ADDR_BITS{1'b0}};
            issued_all_r <= 1'b0;
            m_data_r     <= {RAM_WIDTH{1'b0}};
            m_index_r    <= {RAM_ADDR_BITS{1'b0}};
            m_last_r     <= 1'b0;
            m_valid_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else if (abort && (state_r != ST_IDLE)) begin
            // Cancel wins over load and drain; no completion pulse
            state_r      <= ST_IDLE;
            issued_all_r <= 1'b0;
            m_valid_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        deg_q_r      <= deg;
                        addr_r       <= {RAM_ADDR_BITS{1'b0}};
                        issued_all_r <= 1'b0;
                        busy_r       <= 1'b1;
                        state_r      <= ST_STREAM;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (load_s) begin
                        m_data_r  <= output_data;
                        m_index_r <= addr_r;
                        m_last_r  <= at_deg_s;
                        m_valid_r <= 1'b1;
                        // Hold the address at the degree so it can never wrap
                        if (at_deg_s) begin
                            issued_all_r <= 1'b1;
                        end else begin
                            addr_r <= addr_r + {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
                        end
                    end else if (accept_s) begin
                        m_valid_r <= 1'b0;
                        if (m_last_r) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_STREAM;
                        end
                    end else begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    m_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign read_address = addr_r;
    assign m_data       = m_data_r;
    assign m_index      = m_index_r;
    assign m_last       = m_last_r;
    assign m_valid      = m_valid_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_poly_mem_reader.sv
// Bench for poly_mem_reader: directed passes with a scoreboard queue of
// expected beats, drained by an independent monitor on the falling edge.

module tb_poly_mem_reader;

    localparam int W = 26;
    localparam int A = 11;

    typedef struct packed {
        logic [W-1:0] data;
        logic [A-1:0] idx;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [A-1:0] deg;
    logic [A-1:0] read_address;
    logic [W-1:0] output_data;
    logic [W-1:0] m_data;
    logic [A-1:0] m_index;
    logic         m_last;
    logic         m_valid;
    logic         m_ready;
    logic         busy;
    logic         done;

    logic [W-1:0] mem [0:(1<<A)-1];
    beat_t        exp_q [$];
    int           errors = 0;
    int           checks = 0;
    int           pops   = 0;
    int           cyc    = 0;
    logic         exp_done = 1'b0;
    logic         stall_prev = 1'b0;
    beat_t        held;

    poly_mem_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .deg          (deg),
        .read_address (read_address),
        .output_data  (output_data),
        .m_data       (m_data),
        .m_index      (m_index),
        .m_last       (m_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .busy         (busy),
        .done         (done)
    );

    assign output_data = mem[read_address];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat
    always @(negedge clk) begin
        beat_t got;
        beat_t want;
        if (!rst_n) begin
            exp_done   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (done || exp_done) chk(done == exp_done, "done_after_last", done, exp_done);
            exp_done = 1'b0;
            got = '{data: m_data, idx: m_index, last: m_last};
            if (m_valid && stall_prev) chk(got == held, "stall_stable", got, held);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", got, 64'd0);
                end else begin
                    want = exp_q.pop_front();
                    chk(got == want, "beat", got, want);
                end
                pops++;
                if (m_last) exp_done = 1'b1;
            end
            stall_prev = m_valid && !m_ready;
            held       = got;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [A-1:0] d);
        for (int i = 0; i <= int'(d); i++) begin
            exp_q.push_back('{data: mem[i], idx: A'(i), last: (i == int'(d))});
        end
        start = 1'b1;
        deg   = d;
        tick();
        start = 1'b0;
        deg   = A'($urandom_range(0, (1<<A)-1));
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(done === 1'b1, "done_timeout", done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    t0;
        int    p0;
        int    n;
        bit    pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < (1<<A); i++) mem[i] = W'(32'h100 + i);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; deg = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({read_address, m_data, m_index, m_last, m_valid, busy, done} == '0,
            "reset_outputs", {read_address, m_data, m_index, m_last, m_valid, busy, done}, 0);
        rst_n = 1'b1;
        tick();

        // Basic pass, deg=3, cycle-exact busy/done
        do_start(11'd3);
        t0 = cyc;
        chk(busy == 1'b1 && read_address == 11'd0, "stream_entry", {busy, read_address}, {1'b1, 11'd0});
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk(busy == 1'b1, "busy_during_pass", busy, 1);
        end
        tick();
        chk(cyc == t0 + 5 && done == 1'b1, "basic_done_time", done, 1);
        chk(busy == 1'b0 && m_valid == 1'b0, "basic_after_done", {busy, m_valid}, 0);
        tick();
        chk(done == 1'b0, "done_one_cycle", done, 0);
        chk(exp_q.size() == 0, "basic_all_beats", exp_q.size(), 0);

        // deg=0 single beat, then back-to-back start at minimum spacing
        do_start(11'd0);
        t0 = cyc;
        tick(); tick();
        chk(cyc == t0 + 2 && done == 1'b1, "deg0_done_time", done, 1);
        tick();
        do_start(11'd1);
        chk(busy == 1'b1, "back_to_back_accept", busy, 1);
        wait_done(20);
        chk(exp_q.size() == 0, "b2b_all_beats", exp_q.size(), 0);
        tick();

        // Backpressure with ready pattern 1,0,0,1,0,1...
        do_start(11'd5);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            m_ready = pat[n % 6];
            tick();
            n++;
        end
        chk(done === 1'b1, "bp_done", done, 1);
        chk(exp_q.size() == 0, "bp_all_beats", exp_q.size(), 0);
        m_ready = 1'b1;
        tick();

        // Full address range, no wrap
        p0 = pops;
        do_start(11'd2047);
        wait_done(2200);
        chk(read_address == 11'd2047, "full_addr_hold", read_address, 11'd2047);
        chk(pops - p0 == 2048, "full_beat_count", pops - p0, 2048);
        tick(); tick();
        chk(m_valid == 1'b0 && exp_q.size() == 0, "full_no_extra", m_valid, 0);

        // start during STREAM is ignored
        do_start(11'd4);
        tick();
        start = 1'b1; deg = 11'd7;
        tick();
        start = 1'b0;
        wait_done(40);
        tick(); tick();
        chk(exp_q.size() == 0 && m_valid == 1'b0, "ignored_start", exp_q.size(), 0);
        do_start(11'd2);
        wait_done(20);
        chk(exp_q.size() == 0, "second_pass", exp_q.size(), 0);
        tick();

        // Reset mid-pass at beat 2
        do_start(11'd10);
        n = 0;
        while (!(m_valid && m_index == 11'd2) && n < 20) begin tick(); n++; end
        chk(m_valid && m_index == 11'd2, "reach_beat2", m_index, 2);
        rst_n = 1'b0;
        #1;
        chk({read_address, m_data, m_index, m_last, m_valid, busy, done} == '0,
            "async_reset_outputs", {read_address, m_data, m_index, m_last, m_valid, busy, done}, 0);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk(busy == 1'b0 && m_valid == 1'b0, "idle_after_reset", {busy, m_valid}, 0);
        end

        // Abort at beat 4 while stalled
        p0 = pops;
        do_start(11'd10);
        n = 0;
        while (!(m_valid && m_index == 11'd4) && n < 20) begin tick(); n++; end
        m_ready = 1'b0;
        chk(m_valid && m_index == 11'd4, "reach_beat4", m_index, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk(m_valid == 1'b0 && busy == 1'b0 && done == 1'b0, "abort_idle", {m_valid, busy, done}, 0);
        chk(pops - p0 == 4, "abort_beats_taken", pops - p0, 4);
        exp_q.delete();
        tick(); tick();
        chk(busy == 1'b0 && m_valid == 1'b0, "abort_stays_idle", {busy, m_valid}, 0);
        m_ready = 1'b1;
        do_start(11'd1);
        wait_done(20);
        chk(exp_q.size() == 0, "after_abort_pass", exp_q.size(), 0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
